// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor.
// Consumes DIGIT bits per cycle LSB-first; sum digits enter out at the MSB end.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             mode,
    input  logic             cin,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic             cout,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int NDIG = WIDTH / DIGIT;
    localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_sh;
    logic [WIDTH-1:0] b_sh;
    logic             carry;
    logic [CW-1:0]    cnt;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] sum;
    logic [WIDTH-1:0] out_nx;
    logic             last;

    // Ripple chain over the current low digit of both operands.
    always_comb begin
        chain    = '0;
        sum      = '0;
        chain[0] = carry;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]       = a_sh[i] ^ b_sh[i] ^ chain[i];
            chain[i + 1] = (a_sh[i] & b_sh[i]) |
                           (chain[i] & (a_sh[i] ^ b_sh[i]));
        end
    end

    assign out_nx = (out >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
    assign last   = (cnt == LAST);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (en) state_nx = CALC;
            CALC:    if (last) state_nx = DONE;
            DONE:    if (!en) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            a_sh  <= '0;
            b_sh  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            out   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                IDLE: begin
                    if (en) begin
                        // Subtract is a + ~b + 1, with borrow-in removing the +1.
                        a_sh  <= a;
                        b_sh  <= mode ? ~b : b;
                        carry <= mode ^ cin;
                        cnt   <= '0;
                        out   <= '0;
                        cout  <= 1'b0;
                        ovf   <= 1'b0;
                    end
                end
                CALC: begin
                    out   <= out_nx;
                    a_sh  <= a_sh >> DIGIT;
                    b_sh  <= b_sh >> DIGIT;
                    carry <= chain[DIGIT];
                    cnt   <= cnt + CW'(1);
                    if (last) begin
                        cout <= chain[DIGIT];
                        ovf  <= chain[DIGIT] ^ chain[DIGIT-1];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
